// File: rtl/frame_scheduler.sv
// frame_scheduler: walks one raster frame through the pixel mapper and hands
// each mapped point to an idle iteration engine, round-robin. View config is
// captured at frame start so a frame renders with one consistent view.
module frame_scheduler #(
    parameter int unsigned NUM_ENGINES       = 4,
    parameter int unsigned SCREEN_W          = 640,
    parameter int unsigned SCREEN_H          = 480,
    parameter int unsigned PIXEL_DATA_WIDTH  = 10,
    parameter int unsigned ENGINE_DATA_WIDTH = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [2:0]                   zoom_in,
    input  logic [ENGINE_DATA_WIDTH-1:0] x_offset_in,
    input  logic [ENGINE_DATA_WIDTH-1:0] y_offset_in,
    input  logic                         full_queue,
    output logic                         map_en,
    output logic [PIXEL_DATA_WIDTH-1:0]  map_pixel_x,
    output logic [PIXEL_DATA_WIDTH-1:0]  map_pixel_y,
    output logic [2:0]                   map_zoom,
    output logic [ENGINE_DATA_WIDTH-1:0] map_x_offset,
    output logic [ENGINE_DATA_WIDTH-1:0] map_y_offset,
    input  logic [ENGINE_DATA_WIDTH-1:0] map_real_x,
    input  logic [ENGINE_DATA_WIDTH-1:0] map_imag_y,
    input  logic [NUM_ENGINES-1:0]       eng_ready,
    output logic [NUM_ENGINES-1:0]       eng_start,
    output logic [ENGINE_DATA_WIDTH-1:0] eng_real,
    output logic [ENGINE_DATA_WIDTH-1:0] eng_imag,
    output logic [PIXEL_DATA_WIDTH-1:0]  eng_pixel_x,
    output logic [PIXEL_DATA_WIDTH-1:0]  eng_pixel_y,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int unsigned PW    = PIXEL_DATA_WIDTH;
    localparam int unsigned EW    = ENGINE_DATA_WIDTH;
    localparam int unsigned PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    localparam logic [PW-1:0]    X_LAST   = PW'(SCREEN_W - 1);
    localparam logic [PW-1:0]    Y_LAST   = PW'(SCREEN_H - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ENGINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_MAP,
        S_DISPATCH,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          x_q, x_d, y_q, y_d;
    logic [2:0]             zoom_q, zoom_d;
    logic [EW-1:0]          xoff_q, xoff_d, yoff_q, yoff_d;
    logic                   map_en_q, map_en_d;
    logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
    logic [EW-1:0]          eng_real_q, eng_real_d, eng_imag_q, eng_imag_d;
    logic [PW-1:0]          eng_px_q, eng_px_d, eng_py_q, eng_py_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    logic                   gnt_valid;
    logic [PTR_W-1:0]       gnt_idx;
    int unsigned            cand;
    logic                   last_pixel;

    // First ready engine at or after rr_ptr, circularly; blocked when the result queue is full
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_ENGINES;
            if (!gnt_valid && eng_ready[PTR_W'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(cand);
            end
        end
        if (full_queue) begin
            gnt_valid = 1'b0;
        end
    end

    assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

    // Frame sequencing, dispatch and next-value computation for every register
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        x_d          = x_q;
        y_d          = y_q;
        zoom_d       = zoom_q;
        xoff_d       = xoff_q;
        yoff_d       = yoff_q;
        eng_start_d  = '0;
        eng_real_d   = eng_real_q;
        eng_imag_d   = eng_imag_q;
        eng_px_d     = eng_px_q;
        eng_py_d     = eng_py_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    zoom_d  = zoom_in;
                    xoff_d  = x_offset_in;
                    yoff_d  = y_offset_in;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:    state_d = S_WAIT_MAP;
            S_WAIT_MAP: state_d = S_DISPATCH;
            S_DISPATCH: begin
                if (gnt_valid) begin
                    eng_start_d = NUM_ENGINES'(1) << gnt_idx;
                    eng_real_d  = map_real_x;
                    eng_imag_d  = map_imag_y;
                    eng_px_d    = x_q;
                    eng_py_d    = y_q;
                    rr_ptr_d    = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);
                    if (last_pixel) begin
                        x_d     = '0;
                        y_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + PW'(1);
                        end else begin
                            x_d = x_q + PW'(1);
                        end
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any transition but lets a same-cycle grant pulse out
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b0;
        end

        map_en_d = (state_d == S_ISSUE);
        busy_d   = (state_d != S_IDLE);
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            zoom_q       <= '0;
            xoff_q       <= '0;
            yoff_q       <= '0;
            map_en_q     <= 1'b0;
            eng_start_q  <= '0;
            eng_real_q   <= '0;
            eng_imag_q   <= '0;
            eng_px_q     <= '0;
            eng_py_q     <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            zoom_q       <= zoom_d;
            xoff_q       <= xoff_d;
            yoff_q       <= yoff_d;
            map_en_q     <= map_en_d;
            eng_start_q  <= eng_start_d;
            eng_real_q   <= eng_real_d;
            eng_imag_q   <= eng_imag_d;
            eng_px_q     <= eng_px_d;
            eng_py_q     <= eng_py_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign map_en       = map_en_q;
    assign map_pixel_x  = x_q;
    assign map_pixel_y  = y_q;
    assign map_zoom     = zoom_q;
    assign map_x_offset = xoff_q;
    assign map_y_offset = yoff_q;
    assign eng_start    = eng_start_q;
    assign eng_real     = eng_real_q;
    assign eng_imag     = eng_imag_q;
    assign eng_pixel_x  = eng_px_q;
    assign eng_pixel_y  = eng_py_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler on a 4x2 screen with 4 engines and a behavioural mapper.
module tb_frame_scheduler;

    localparam int NE   = 4;
    localparam int SW   = 4;
    localparam int SH   = 2;
    localparam int PW   = 10;
    localparam int EW   = 25;
    localparam int NPIX = SW * SH;

    logic          clk = 1'b0;
    logic          reset, start, abort, full_queue;
    logic [2:0]    zoom_in;
    logic [EW-1:0] x_offset_in, y_offset_in;
    logic          map_en;
    logic [PW-1:0] map_pixel_x, map_pixel_y;
    logic [2:0]    map_zoom;
    logic [EW-1:0] map_x_offset, map_y_offset;
    logic [EW-1:0] map_real_x, map_imag_y;
    logic [NE-1:0] eng_ready, eng_start;
    logic [EW-1:0] eng_real, eng_imag;
    logic [PW-1:0] eng_pixel_x, eng_pixel_y;
    logic          busy, frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model of the frame: pixel index, cycles since issue, rr pointer, latched view
    bit            m_active, m_done;
    int            m_pix, m_age, m_rr;
    logic [2:0]    m_zoom;
    logic [EW-1:0] m_xoff, m_yoff;
    logic [NE-1:0] e_start;
    bit            e_map_en, e_busy, e_done;
    int            e_px, e_py, e_mpx, e_mpy, e_gnt;

    frame_scheduler #(
        .NUM_ENGINES(NE), .SCREEN_W(SW), .SCREEN_H(SH),
        .PIXEL_DATA_WIDTH(PW), .ENGINE_DATA_WIDTH(EW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .zoom_in(zoom_in), .x_offset_in(x_offset_in), .y_offset_in(y_offset_in),
        .full_queue(full_queue), .map_en(map_en),
        .map_pixel_x(map_pixel_x), .map_pixel_y(map_pixel_y),
        .map_zoom(map_zoom), .map_x_offset(map_x_offset), .map_y_offset(map_y_offset),
        .map_real_x(map_real_x), .map_imag_y(map_imag_y),
        .eng_ready(eng_ready), .eng_start(eng_start),
        .eng_real(eng_real), .eng_imag(eng_imag),
        .eng_pixel_x(eng_pixel_x), .eng_pixel_y(eng_pixel_y),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Coordinate mapping used by both the stand-in mapper and the expectations
    function automatic logic [EW-1:0] map_fn(input int p, input logic [2:0] z, input logic [EW-1:0] off);
        int v;
        v = (p << z) + int'($signed(off));
        return EW'(v);
    endfunction

    // Stand-in mapper: registers its result on map_en
    always @(posedge clk) begin
        if (reset) begin
            map_real_x <= '0;
            map_imag_y <= '0;
        end else if (map_en) begin
            map_real_x <= map_fn(int'(map_pixel_x), map_zoom, map_x_offset);
            map_imag_y <= map_fn(int'(map_pixel_y), map_zoom, map_y_offset);
        end
    end

    // Advance the model over one clock edge using the currently driven inputs, then step the clock
    task automatic tick();
        int g, c, rm;
        e_start  = '0;
        e_map_en = 0;
        e_done   = 0;
        e_gnt    = -1;
        rm       = int'(eng_ready);
        if (reset) begin
            m_active = 0; m_done = 0; m_rr = 0; m_pix = 0; m_age = 0;
            m_zoom = '0; m_xoff = '0; m_yoff = '0;
        end else if (m_done) begin
            m_done = 0;
            e_done = !abort;
        end else if (m_active) begin
            if (m_age == 2 && !full_queue && rm != 0) begin
                g = -1;
                for (int k = 0; k < NE; k++) begin
                    c = (m_rr + k) % NE;
                    if (g < 0 && ((rm >> c) & 1) == 1) g = c;
                end
                e_gnt   = g;
                e_start = NE'(1) << g;
                m_rr    = (g + 1) % NE;
                e_px    = m_pix % SW;
                e_py    = m_pix / SW;
                if (abort) m_active = 0;
                else if (m_pix == NPIX - 1) begin
                    m_active = 0;
                    m_done   = 1;
                end else begin
                    m_pix++;
                    m_age    = 0;
                    e_map_en = 1;
                end
            end else if (abort) begin
                m_active = 0;
            end else if (m_age < 2) begin
                m_age++;
            end
        end else if (start) begin
            m_active = 1; m_pix = 0; m_age = 0; e_map_en = 1;
            m_zoom = zoom_in; m_xoff = x_offset_in; m_yoff = y_offset_in;
        end
        e_mpx  = m_pix % SW;
        e_mpy  = m_pix / SW;
        e_busy = m_active || m_done;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; start = 1;
        repeat (2) begin
            tick();
            checks++;
            if ({eng_start, map_en, busy, frame_done, map_zoom, map_x_offset, map_y_offset, eng_real,
                 eng_imag, eng_pixel_x, eng_pixel_y, map_pixel_x, map_pixel_y} !== '0) begin
                errors++;
                $display("FAIL reset outputs: got start=%b map_en=%b busy=%b done=%b zoom=%0d xo=%h real=%h px=%0d want all zero",
                         eng_start, map_en, busy, frame_done, map_zoom, map_x_offset, eng_real, eng_pixel_x);
            end
        end
        reset = 0; start = 0;
        tick();
        checks++;
        if ({busy, map_en, eng_start} !== '0) begin
            errors++;
            $display("FAIL reset idle: got busy=%b map_en=%b start=%b want 0 0 0", busy, map_en, eng_start);
        end
    endtask

    task automatic test_single_frame();
        int gl[$], pl[$], last_gnt_at, done_at, ndone, es;
        last_gnt_at = -10; done_at = -1; ndone = 0;
        zoom_in = 3'd0; x_offset_in = '0; y_offset_in = '0; eng_ready = 4'b1111; full_queue = 0; abort = 0;
        start = 1;
        tick();
        start = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            checks++;
            if ({eng_start, map_en, busy, frame_done} !== {e_start, e_map_en, e_busy, e_done}) begin
                errors++;
                $display("FAIL single ctrl: start/map_en/busy/done got %b %b %b %b want %b %b %b %b",
                         eng_start, map_en, busy, frame_done, e_start, e_map_en, e_busy, e_done);
            end
            if (e_start != '0) begin
                checks++;
                if ({eng_pixel_x, eng_pixel_y, eng_real, eng_imag} !==
                    {PW'(e_px), PW'(e_py), map_fn(e_px, m_zoom, m_xoff), map_fn(e_py, m_zoom, m_yoff)}) begin
                    errors++;
                    $display("FAIL single bus: got (%0d,%0d) %h %h want (%0d,%0d) %h %h", eng_pixel_x, eng_pixel_y,
                             eng_real, eng_imag, e_px, e_py, map_fn(e_px, m_zoom, m_xoff), map_fn(e_py, m_zoom, m_yoff));
                end
            end
            es = int'(eng_start);
            for (int k = 0; k < NE; k++) if (((es >> k) & 1) == 1) gl.push_back(k);
            if (es != 0) begin
                pl.push_back(int'(eng_pixel_y) * SW + int'(eng_pixel_x));
                last_gnt_at = cyc;
            end
            if (frame_done) begin
                ndone++;
                done_at = cyc;
            end
            if (!m_active && !m_done) break;
        end
        checks++;
        if (gl.size() != NPIX) begin
            errors++;
            $display("FAIL single count: got %0d dispatches want %0d", gl.size(), NPIX);
        end
        for (int i = 0; i < gl.size() && i < NPIX; i++) begin
            checks++;
            if (gl[i] != i % NE || pl[i] != i) begin
                errors++;
                $display("FAIL single order %0d: got engine %0d pixel %0d want engine %0d pixel %0d", i, gl[i], pl[i], i % NE, i);
            end
        end
        checks++;
        if (ndone != 1 || done_at != last_gnt_at + 1) begin
            errors++;
            $display("FAIL single done: got %0d pulses at %0d want 1 at %0d", ndone, done_at, last_gnt_at + 1);
        end
    endtask

    task automatic test_rr_skip();
        int ng, got[$];
        ng = 0;
        eng_ready = 4'b1111; full_queue = 0; abort = 0;
        start = 1;
        tick();
        start = 0;
        for (int cyc = 0; cyc < 50 && ng < 2; cyc++) begin
            tick();
            if (eng_start != '0) ng++;
        end
        abort = 1;
        tick();
        abort = 0;
        tick();
        eng_ready = 4'b0011;
        start = 1;
        tick();
        start = 0;
        for (int cyc = 0; cyc < 50 && got.size() < 2; cyc++) begin
            tick();
            checks++;
            if ({eng_start, map_en, busy, frame_done} !== {e_start, e_map_en, e_busy, e_done}) begin
                errors++;
                $display("FAIL rr ctrl: start/map_en/busy/done got %b %b %b %b want %b %b %b %b",
                         eng_start, map_en, busy, frame_done, e_start, e_map_en, e_busy, e_done);
            end
            if (eng_start != '0) got.push_back(int'(eng_start));
        end
        checks++;
        if (got.size() != 2 || got[0] != 1 || got[1] != 2) begin
            errors++;
            $display("FAIL rr skip: got %0d grants first=%b second=%b want 0001 then 0010", got.size(),
                     got.size() > 0 ? got[0] : -1, got.size() > 1 ? got[1] : -1);
        end
        abort = 1;
        tick();
        abort = 0;
        eng_ready = 4'b1111;
        tick();
    endtask

    task automatic test_stall();
        logic [2*PW+2*EW-1:0] snap;
        eng_ready = 4'b1111; full_queue = 1; abort = 0;
        start = 1;
        tick();
        start = 0;
        snap = {eng_pixel_x, eng_pixel_y, eng_real, eng_imag};
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            checks++;
            if (eng_start !== '0 || e_start != '0 || {eng_pixel_x, eng_pixel_y, eng_real, eng_imag} !== snap) begin
                errors++;
                $display("FAIL stall %0d: got start=%b bus=%h want start=0000 bus=%h", cyc, eng_start,
                         {eng_pixel_x, eng_pixel_y, eng_real, eng_imag}, snap);
            end
        end
        full_queue = 0;
        tick();
        checks++;
        if (eng_start === '0 || eng_start !== e_start) begin
            errors++;
            $display("FAIL stall release: got start=%b want %b", eng_start, e_start);
        end
        abort = 1;
        tick();
        abort = 0;
        tick();
    endtask

    task automatic test_config_latch();
        logic [EW-1:0] xo;
        bit fin;
        fin = 0;
        xo = EW'(32'h0000123);
        eng_ready = 4'b1111; full_queue = 0; abort = 0;
        zoom_in = 3'd3; x_offset_in = xo; y_offset_in = EW'(-5);
        start = 1;
        tick();
        start = 0;
        zoom_in = 3'd5; x_offset_in = EW'(32'h1ABCDE); y_offset_in = EW'(77);
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            checks++;
            if (busy && (map_zoom !== 3'd3 || map_x_offset !== xo)) begin
                errors++;
                $display("FAIL cfg latch: got zoom=%0d xoff=%h want 3 %h", map_zoom, map_x_offset, xo);
            end
            if (e_start != '0) begin
                checks++;
                if ({eng_pixel_x, eng_pixel_y, eng_real, eng_imag} !==
                    {PW'(e_px), PW'(e_py), map_fn(e_px, m_zoom, m_xoff), map_fn(e_py, m_zoom, m_yoff)}) begin
                    errors++;
                    $display("FAIL cfg bus: got (%0d,%0d) %h %h want (%0d,%0d) %h %h", eng_pixel_x, eng_pixel_y,
                             eng_real, eng_imag, e_px, e_py, map_fn(e_px, m_zoom, m_xoff), map_fn(e_py, m_zoom, m_yoff));
                end
            end
            if (!m_active && !m_done) begin
                fin = 1;
                break;
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL cfg timeout: frame still active want idle");
        end
        start = 1;
        tick();
        start = 0;
        checks++;
        if (map_zoom !== 3'd5 || map_x_offset !== EW'(32'h1ABCDE)) begin
            errors++;
            $display("FAIL cfg relatch: got zoom=%0d xoff=%h want 5 %h", map_zoom, map_x_offset, EW'(32'h1ABCDE));
        end
        abort = 1;
        tick();
        abort = 0;
        tick();
    endtask

    task automatic test_abort();
        bit seen;
        seen = 0;
        eng_ready = 4'b1111; full_queue = 0; abort = 0;
        start = 1;
        tick();
        start = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (map_en && map_pixel_x == PW'(2) && map_pixel_y == PW'(0)) begin
                seen = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort setup: pixel (2,0) never issued want issued");
        end
        abort = 1;
        tick();
        abort = 0;
        checks++;
        if (busy !== 1'b0 || e_busy) begin
            errors++;
            $display("FAIL abort idle: got busy=%b want 0", busy);
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            checks++;
            if (eng_start !== '0 || frame_done !== 1'b0 || map_en !== 1'b0) begin
                errors++;
                $display("FAIL abort quiet %0d: got start=%b done=%b map_en=%b want 0", cyc, eng_start, frame_done, map_en);
            end
        end
        start = 1;
        tick();
        start = 0;
        checks++;
        if (map_en !== 1'b1 || map_pixel_x !== PW'(0) || map_pixel_y !== PW'(0)) begin
            errors++;
            $display("FAIL abort restart: got map_en=%b (%0d,%0d) want 1 (0,0)", map_en, map_pixel_x, map_pixel_y);
        end
        abort = 1;
        tick();
        abort = 0;
        tick();
    endtask

    task automatic test_random();
        bit fin;
        for (int fr = 0; fr < 6; fr++) begin
            fin = 0;
            zoom_in = 3'($urandom_range(0, 7));
            x_offset_in = EW'($urandom);
            y_offset_in = EW'($urandom);
            abort = 0;
            start = 1;
            tick();
            for (int cyc = 0; cyc < 600; cyc++) begin
                eng_ready   = NE'($urandom_range(0, 15));
                full_queue  = ($urandom_range(0, 3) == 0);
                abort       = ($urandom_range(0, 149) == 0);
                start       = ($urandom_range(0, 1) == 0);
                zoom_in     = 3'($urandom_range(0, 7));
                x_offset_in = EW'($urandom);
                tick();
                checks++;
                if ({eng_start, map_en, busy, frame_done} !== {e_start, e_map_en, e_busy, e_done}) begin
                    errors++;
                    $display("FAIL rand ctrl f%0d: start/map_en/busy/done got %b %b %b %b want %b %b %b %b", fr,
                             eng_start, map_en, busy, frame_done, e_start, e_map_en, e_busy, e_done);
                end
                if (e_map_en) begin
                    checks++;
                    if ({map_pixel_x, map_pixel_y} !== {PW'(e_mpx), PW'(e_mpy)}) begin
                        errors++;
                        $display("FAIL rand issue: got (%0d,%0d) want (%0d,%0d)", map_pixel_x, map_pixel_y, e_mpx, e_mpy);
                    end
                end
                if (e_start != '0) begin
                    checks++;
                    if ({eng_pixel_x, eng_pixel_y, eng_real, eng_imag} !==
                        {PW'(e_px), PW'(e_py), map_fn(e_px, m_zoom, m_xoff), map_fn(e_py, m_zoom, m_yoff)}) begin
                        errors++;
                        $display("FAIL rand bus: got (%0d,%0d) %h %h want (%0d,%0d) %h %h", eng_pixel_x, eng_pixel_y,
                                 eng_real, eng_imag, e_px, e_py, map_fn(e_px, m_zoom, m_xoff), map_fn(e_py, m_zoom, m_yoff));
                    end
                end
                if (busy && map_zoom !== m_zoom) begin
                    errors++;
                    $display("FAIL rand zoom: got %0d want %0d", map_zoom, m_zoom);
                end
                if (!m_active && !m_done) begin
                    fin = 1;
                    break;
                end
            end
            start = 0; abort = 0;
            checks++;
            if (!fin) begin
                errors++;
                $display("FAIL rand timeout f%0d: frame still active want idle", fr);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1; start = 0; abort = 0; full_queue = 0; eng_ready = '0;
        zoom_in = '0; x_offset_in = '0; y_offset_in = '0;
        test_reset();
        test_single_frame();
        test_rr_skip();
        test_stall();
        test_config_latch();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
